// File: rtl/vga_text_renderer.sv
// vga_text_renderer: text-mode VGA pixel pipeline (timing, text/font fetch, cursor blink)
module vga_text_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] text_addr,
  input  logic [15:0] text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic        fb,
  output logic [3:0]  fg_color,
  output logic [3:0]  bg_color,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [9:0] h_cnt, v_cnt;
  logic [4:0] frame_cnt;
  logic       cur_en_q;
  logic [6:0] cur_x_q;
  logic [4:0] cur_y_q;
  logic       h_wrap, v_wrap, act0, hs0, vs0, origin;
  logic       act1, hs1, vs1, fs1;
  logic [3:0] g1;
  logic [2:0] px1;
  logic [6:0] col1;
  logic [4:0] row1;
  logic       act2, hs2, vs2, fs2, hit2;
  logic [2:0] px2;
  logic [3:0] fg2, bg2;
  logic       hit1, fb_raw;
  assign h_wrap = h_cnt == 10'(H_TOTAL - 1);
  assign v_wrap = v_cnt == 10'(V_TOTAL - 1);
  assign origin = h_cnt == '0 && v_cnt == '0;
  assign act0 = h_cnt < 10'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
  assign hs0 = h_cnt >= 10'(H_ACTIVE + H_FP) && h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC);
  assign vs0 = v_cnt >= 10'(V_ACTIVE + V_FP) && v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC);
  // blanking and reset park the address at cell 0 so it never leaves the grid
  assign text_addr = (rst_n && act0 && v_cnt[8:4] < 5'(ROWS)) ?
                     12'(v_cnt[8:4]) * 12'(COLS) + 12'(h_cnt[9:3]) : '0;
  assign font_addr = rst_n ? {text_data[7:0], g1} : '0;
  assign hit1 = cur_en_q && frame_cnt[4] && col1 == cur_x_q && row1 == cur_y_q && &g1[3:1];
  assign fb_raw = font_data[3'd7 - px2];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      frame_cnt <= '0;
      cur_en_q <= 1'b0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      {act1, hs1, vs1, fs1, g1, px1, col1, row1} <= '0;
      {act2, hs2, vs2, fs2, hit2, px2, fg2, bg2} <= '0;
      fb <= 1'b0;
      fg_color <= '0;
      bg_color <= '0;
      de <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 5'd1;
      if (origin) begin
        cur_en_q <= cursor_en;
        cur_x_q <= cursor_x;
        cur_y_q <= cursor_y;
      end
      act1 <= act0;
      hs1 <= hs0;
      vs1 <= vs0;
      fs1 <= act0 && origin;
      g1 <= v_cnt[3:0];
      px1 <= h_cnt[2:0];
      col1 <= h_cnt[9:3];
      row1 <= v_cnt[8:4];
      act2 <= act1;
      hs2 <= hs1;
      vs2 <= vs1;
      fs2 <= fs1;
      hit2 <= hit1;
      px2 <= px1;
      fg2 <= text_data[11:8];
      bg2 <= text_data[15:12];
      fb <= act2 && (fb_raw || hit2);
      fg_color <= act2 ? fg2 : '0;
      bg_color <= act2 ? bg2 : '0;
      de <= act2;
      hsync <= !hs2;
      vsync <= !vs2;
      frame_start <= fs2;
    end
  end
endmodule

// File: tb/tb_vga_text_renderer.sv
// tb_vga_text_renderer: directed checks on a full-size instance and a shrunken-timing instance
module tb_vga_text_renderer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] a_taddr, a_faddr, b_taddr, b_faddr;
  logic [15:0] a_tdata, b_tdata;
  logic [7:0]  a_fdata, b_fdata;
  logic        a_fb, a_hs, a_vs, a_de, a_fs;
  logic [3:0]  a_fg, a_bg;
  logic        b_fb, b_hs, b_vs, b_de, b_fs;
  logic [3:0]  b_fg, b_bg;
  logic        b_cen = 1'b1;
  logic [6:0]  b_cx = 7'd3;
  logic [4:0]  b_cy = 5'd1;
  logic [7:0]  pat = 8'b1000_0001;
  int n_vec = 0, n_err = 0;
  int a_de_n = 0, a_hs_n = 0, hs_low = 0, kk = 0;
  int fo, oh, ov;
  int fbc[33], dec[33], vsc[33], fsc[33], hmin[33], vmin[33];

  always #5 clk = ~clk;

  // synchronous memory models, one cycle of read latency
  always @(posedge clk) begin
    a_tdata <= (a_taddr == 12'd0) ? 16'h2141 : 16'h0000;
    a_fdata <= (a_faddr[11:4] == 8'h41) ? 8'h81 : 8'h00;
    b_tdata <= {8'hA5, b_taddr[7:0]};
    b_fdata <= 8'h00;
  end

  vga_text_renderer dut_a (
    .clk(clk), .rst_n(rst_n), .text_addr(a_taddr), .text_data(a_tdata),
    .font_addr(a_faddr), .font_data(a_fdata), .cursor_en(1'b0), .cursor_x(7'd0),
    .cursor_y(5'd0), .fb(a_fb), .fg_color(a_fg), .bg_color(a_bg), .hsync(a_hs),
    .vsync(a_vs), .de(a_de), .frame_start(a_fs)
  );

  // 40x36 timing, 4x2 cells: one frame is 1440 cycles so blink fits in budget
  vga_text_renderer #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(1), .COLS(4), .ROWS(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .text_addr(b_taddr), .text_data(b_tdata),
    .font_addr(b_faddr), .font_data(b_fdata), .cursor_en(b_cen), .cursor_x(b_cx),
    .cursor_y(b_cy), .fb(b_fb), .fg_color(b_fg), .bg_color(b_bg), .hsync(b_hs),
    .vsync(b_vs), .de(b_de), .frame_start(b_fs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int f = 0; f < 33; f++) begin
      fbc[f] = 0; dec[f] = 0; vsc[f] = 0; fsc[f] = 0; hmin[f] = 99; vmin[f] = 99;
    end
    for (int i = 0; i < 10; i++) tick();
    chk("reset_out_a", {a_fb, a_fg, a_bg, a_de, a_hs, a_vs, a_fs}, 13'b0_0000_0000_0110);
    chk("reset_out_b", {b_fb, b_fg, b_bg, b_de, b_hs, b_vs, b_fs}, 13'b0_0000_0000_0110);
    chk("reset_addr_a", {a_taddr, a_faddr}, 24'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 47522; k++) begin
      tick();
      if (k == 1) chk("font_addr_line0", a_faddr, 12'h410);
      if (k == 2) chk("de_fs_cycle2", {a_de, a_fs}, 2'b00);
      if (k == 3) chk("first_px_a", {a_de, a_fs, a_fg, a_bg}, {1'b1, 1'b1, 4'h1, 4'h2});
      if (k == 3) chk("first_px_b", {b_de, b_fs}, 2'b11);
      if (k >= 3 && k <= 10) chk("glyph_px", a_fb, pat[10-k]);
      if (k == 4) chk("fs_cycle4", a_fs, 1'b0);
      if (k == 8) chk("text_addr_cell1", a_taddr, 12'd1);
      if (k == 639) chk("text_addr_col79", a_taddr, 12'd79);
      if (k == 640) chk("text_addr_hblank", a_taddr, 12'd0);
      if (k == 642) chk("de_last_px", a_de, 1'b1);
      if (k == 643) chk("blank_out", {a_de, a_fb, a_fg, a_bg}, 10'h0);
      if (k == 658) chk("hsync_before", a_hs, 1'b1);
      if (k == 659) chk("hsync_start", a_hs, 1'b0);
      if (k == 754) chk("hsync_end", a_hs, 1'b0);
      if (k == 755) chk("hsync_after", a_hs, 1'b1);
      if (k == 1271) chk("text_addr_b_last", b_taddr, 12'd7);
      if (k == 1272) chk("addr_b_blank", {b_taddr, b_faddr}, {12'd0, 12'h07F});
      if (k >= 3 && k <= 802) begin
        a_de_n += int'(a_de);
        a_hs_n += int'(!a_hs);
      end
      if (k >= 3) begin
        fo = (k - 3) / 1440;
        oh = (k - 3) % 40;
        ov = ((k - 3) / 40) % 36;
        fbc[fo] += int'(b_fb);
        dec[fo] += int'(b_de);
        vsc[fo] += int'(!b_vs);
        fsc[fo] += int'(b_fs);
        if (b_fb && oh < hmin[fo]) hmin[fo] = oh;
        if (b_fb && ov < vmin[fo]) vmin[fo] = ov;
      end
      if (k == 29500) b_cx = 7'd0;
    end
    chk("de_per_line", a_de_n, 640);
    chk("hsync_per_line", a_hs_n, 96);
    for (int f = 0; f < 33; f++) chk("blink_fb_count", fbc[f], (f >= 16 && f <= 31) ? 16 : 0);
    chk("cursor_h_f16", hmin[16], 24);
    chk("cursor_v_f16", vmin[16], 30);
    chk("cursor_h_f20", hmin[20], 24);
    chk("cursor_h_f21", hmin[21], 0);
    chk("cursor_h_f31", hmin[31], 0);
    chk("de_frame0_b", dec[0], 1024);
    chk("de_frame1_b", dec[1], 1024);
    chk("vsync_frame0_b", vsc[0], 80);
    chk("fs_frame0_b", fsc[0], 1);
    chk("fs_frame31_b", fsc[31], 1);
    kk = 47522;
    while (kk % 800 != 300) begin
      tick();
      kk++;
    end
    chk("de_before_midreset", a_de, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("midreset_out", {a_fb, a_fg, a_bg, a_de, a_hs, a_vs, a_fs}, 13'b0_0000_0000_0110);
    chk("midreset_addr", a_taddr, 12'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 660; k++) begin
      tick();
      if (k <= 658) hs_low += int'(!a_hs);
      if (k == 2) chk("restart_de_c2", a_de, 1'b0);
      if (k == 3) chk("restart_de_fs", {a_de, a_fs}, 2'b11);
      if (k == 659) chk("restart_hsync", a_hs, 1'b0);
    end
    chk("no_short_hsync", hs_low, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
